// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered WIDTH-bit ALU with valid/ready handshakes and iterative multiply
//
// Purpose:
//   Single-cycle ALU ops (add/sub/logic/shift) register their result one clock
//   after acceptance. MUL runs as a WIDTH-cycle shift-add with the input stalled.
//   A single output register holds each result until the consumer takes it.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands/op presented
//   in_ready   out  1      block can accept this cycle
//   in_op      in   4      operation select
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B / shift amount (low $clog2(WIDTH) bits)
//   out_valid  out  1      output register holds an unconsumed result
//   out_ready  in   1      consumer accepts the result
//   out_result out  WIDTH  result
//   out_flags  out  4      {N,Z,C,V}
//   out_err    out  1      result came from an illegal op
//   busy       out  1      multiply in progress
module alu_pipe #(
  parameter int WIDTH      = 16,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_err,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NTA = 4'h5;
  localparam logic [3:0] OP_NTB = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_SRA = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;

  typedef enum logic {IDLE, MUL} state_t;

  state_t state_q, state_d;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [SW-1:0]      cnt;
  logic               mul_last;

  logic               accept;
  logic               is_mul;

  logic [WIDTH-1:0]   res_c;
  logic               c_c;
  logic               v_c;
  logic               err_c;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [WIDTH:0]     sra_ext;
  logic [SW-1:0]      amt;

  assign busy     = (state_q == MUL);
  assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = ENABLE_MUL && (in_op == OP_MUL);

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == SW'(WIDTH - 1));

  // Single-cycle datapath. Shifts are done one bit wider than the operand so
  // the last bit shifted out lands in the extra position and becomes C; with
  // a zero shift amount that position only ever holds the padding zero.
  always_comb begin
    res_c   = '0;
    c_c     = 1'b0;
    v_c     = 1'b0;
    err_c   = 1'b0;
    amt     = in_b[SW-1:0];
    sum     = {1'b0, in_a} + {1'b0, in_b};
    diff    = {1'b0, in_a} - {1'b0, in_b};
    shl_ext = {1'b0, in_a} << amt;
    shr_ext = {in_a, 1'b0} >> amt;
    sra_ext = $signed({in_a, 1'b0}) >>> amt;
    case (in_op)
      OP_ADD: begin
        res_c = sum[WIDTH-1:0];
        c_c   = sum[WIDTH];
        v_c   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (res_c[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = diff[WIDTH-1:0];
        c_c   = ~diff[WIDTH];
        v_c   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (res_c[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND: res_c = in_a & in_b;
      OP_OR:  res_c = in_a | in_b;
      OP_XOR: res_c = in_a ^ in_b;
      OP_NTA: res_c = ~in_a;
      OP_NTB: res_c = ~in_b;
      OP_SHL: begin
        res_c = shl_ext[WIDTH-1:0];
        c_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        res_c = shr_ext[WIDTH:1];
        c_c   = shr_ext[0];
      end
      OP_SRA: begin
        res_c = sra_ext[WIDTH:1];
        c_c   = sra_ext[0];
      end
      default: err_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mul) state_d = MUL;
      MUL:     if (mul_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      out_err    <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        if (is_mul) begin
          mcand     <= {{WIDTH{1'b0}}, in_a};
          mplier    <= in_b;
          acc       <= '0;
          cnt       <= '0;
          out_valid <= 1'b0;
        end else begin
          out_result <= res_c;
          out_flags  <= {res_c[WIDTH-1], (res_c == '0), c_c, v_c};
          out_err    <= err_c;
          out_valid  <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end else begin
      // Output slot was emptied at MUL acceptance, so completion never
      // overwrites an unconsumed result.
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (mul_last) begin
        out_result <= acc_next[WIDTH-1:0];
        out_flags  <= {acc_next[WIDTH-1], (acc_next[WIDTH-1:0] == '0),
                       (acc_next[2*WIDTH-1:WIDTH] != '0), 1'b0};
        out_err    <= 1'b0;
        out_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard testbench for alu_pipe (WIDTH=16, ENABLE_MUL=1)
module tb_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic        out_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [20:0] exp_q[$];
  int          pop_cyc[$];

  alu_pipe #(.WIDTH(16), .ENABLE_MUL(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_err    (out_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_res(input logic [15:0] res, input logic [3:0] flags, input logic err);
    exp_q.push_back({res, flags, err});
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("send_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: pops one expected entry per consumed result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h expected=none", {out_result, out_flags, out_err});
      end else begin
        check("result", {out_result, out_flags, out_err}, exp_q.pop_front());
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 4'h0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {out_valid, busy, out_result, out_flags, out_err}, 23'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed single-cycle vectors, streamed with out_ready high.
    expect_res(16'h0000, 4'b0110, 1'b0); send(4'h0, 16'hFFFF, 16'h0001);
    expect_res(16'h7FFF, 4'b0011, 1'b0); send(4'h1, 16'h8000, 16'h0001);
    expect_res(16'hFFFF, 4'b1000, 1'b0); send(4'h1, 16'h0001, 16'h0002);
    expect_res(16'h0002, 4'b0010, 1'b0); send(4'h7, 16'h8001, 16'h0001);
    expect_res(16'hF000, 4'b1000, 1'b0); send(4'h9, 16'h8000, 16'h0013);
    expect_res(16'h1234, 4'b0000, 1'b0); send(4'h8, 16'h1234, 16'h0000);
    expect_res(16'h0001, 4'b0010, 1'b0); send(4'h8, 16'h0003, 16'h0001);
    expect_res(16'h00F0, 4'b0000, 1'b0); send(4'h2, 16'hF0F0, 16'h0FF0);
    expect_res(16'h8001, 4'b1000, 1'b0); send(4'h3, 16'h8000, 16'h0001);
    expect_res(16'h0000, 4'b0100, 1'b0); send(4'h4, 16'hAAAA, 16'hAAAA);
    expect_res(16'hFF00, 4'b1000, 1'b0); send(4'h5, 16'h00FF, 16'h1234);
    expect_res(16'h0000, 4'b0100, 1'b0); send(4'h6, 16'h1234, 16'hFFFF);
    expect_res(16'h8000, 4'b1001, 1'b0); send(4'h0, 16'h7FFF, 16'h0001);
    expect_res(16'h0000, 4'b0100, 1'b1); send(4'hF, 16'h1234, 16'h5678);
    expect_res(16'h0000, 4'b0100, 1'b1); send(4'hB, 16'hFFFF, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back stream: eight results on eight consecutive cycles.
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      expect_res(16'(i + 16'h0010), 4'b0000, 1'b0);
      send(4'h0, 16'(i), 16'h0010);
    end
    repeat (3) @(posedge clk);
    #1;
    check("stream_count", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) check("stream_span", pop_cyc[7] - pop_cyc[0], 7);

    // Output hold under back-pressure; a pending input must not be lost.
    out_ready = 1'b0;
    expect_res(16'h0003, 4'b0000, 1'b0);
    send(4'h0, 16'h0001, 16'h0002);
    in_valid = 1'b1; in_op = 4'h0; in_a = 16'h0005; in_b = 16'h0006;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold", {out_valid, in_ready, busy, out_flags, out_err, out_result},
            {1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0003});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    expect_res(16'h000B, 4'b0000, 1'b0);
    send(4'h0, 16'h0005, 16'h0006);
    repeat (2) @(posedge clk);
    #1;

    // MUL latency, busy and in_ready during the multiply; in_valid is ignored.
    expect_res(16'h1230, 4'b0000, 1'b0);
    send(4'hA, 16'h0123, 16'h0010);
    in_valid = 1'b1; in_op = 4'h0; in_a = 16'h1111; in_b = 16'h2222;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 10) in_valid = 1'b0;
      check("mul_pending", {out_valid, busy, in_ready}, 3'b010);
    end
    @(negedge clk);
    check("mul_done", {out_valid, busy}, 2'b10);
    @(posedge clk);
    #1;

    expect_res(16'h0000, 4'b0110, 1'b0);
    send(4'hA, 16'h1000, 16'h0010);
    repeat (18) @(posedge clk);
    #1;
    check("mul2_drained", exp_q.size(), 0);

    // Reset in the middle of a multiply discards it.
    send(4'hA, 16'h0005, 16'h0003);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_mul_reset", {out_valid, busy, out_result, out_flags, out_err}, 23'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {in_ready, busy}, 2'b10);
    repeat (25) @(negedge clk);
    check("no_stale_result", out_valid, 1'b0);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
